// File: rtl/if_id_if.sv
// IF/ID pipeline-register bus: fetch inputs, ID/EX hazard feedback and decode-side outputs.
// Statistics ports exist only when IF_ID_HAZARD_STATS_EN is defined.
interface if_id_if;
  logic [31:0] pcPlus4In;
  logic [31:0] instrIn;
  logic        flush;
  logic        idExMemread;
  logic [4:0]  idExIns20_16;
  logic [31:0] pcPlus4;
  logic [31:0] instr;
  logic        valid;
  logic        pcWrite;
  logic        bubble;
`ifdef IF_ID_HAZARD_STATS_EN
  logic [31:0] stallCount;
  logic [31:0] flushCount;
`endif

  modport master (
    output pcPlus4In, instrIn, flush, idExMemread, idExIns20_16,
`ifdef IF_ID_HAZARD_STATS_EN
    input  stallCount, flushCount,
`endif
    input  pcPlus4, instr, valid, pcWrite, bubble
  );

  modport slave (
    input  pcPlus4In, instrIn, flush, idExMemread, idExIns20_16,
`ifdef IF_ID_HAZARD_STATS_EN
    output stallCount, flushCount,
`endif
    output pcPlus4, instr, valid, pcWrite, bubble
  );
endinterface

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with one-cycle load-use stall and flush squash.
// Define IF_ID_HAZARD_STATS_EN to add the stallCount/flushCount statistics outputs.
module if_id_stage (
  input logic    clk,
  input logic    startin,
  if_id_if.slave bus
);

  typedef enum logic [0:0] {StRun, StHold} state_e;

  state_e      state_q;
  logic [31:0] pc_plus4_q;
  logic [31:0] instr_q;
  logic        valid_q;

  logic [4:0]  rs;
  logic [4:0]  rt;
  logic        src_match;
  logic        hz;
  logic        stall;

  always_comb begin
    rs        = instr_q[25:21];
    rt        = instr_q[20:16];
    src_match = (bus.idExIns20_16 == rs) || (bus.idExIns20_16 == rt);
    // HOLD masks the hazard so a persistent load-use condition costs only one bubble.
    hz        = (state_q == StRun) && valid_q && bus.idExMemread &&
                (bus.idExIns20_16 != 5'd0) && src_match;
    stall     = hz && !bus.flush && !startin;
  end

  assign bus.pcWrite = !startin && !stall;
  assign bus.bubble  = stall;
  assign bus.pcPlus4 = pc_plus4_q;
  assign bus.instr   = instr_q;
  assign bus.valid   = valid_q;

  always_ff @(posedge clk) begin
    if (startin) begin
      state_q    <= StRun;
      pc_plus4_q <= 32'd0;
      instr_q    <= 32'd0;
      valid_q    <= 1'b0;
    end else if (bus.flush) begin
      state_q    <= StRun;
      pc_plus4_q <= 32'd0;
      instr_q    <= 32'd0;
      valid_q    <= 1'b0;
    end else if (stall) begin
      state_q    <= StHold;
    end else begin
      state_q    <= StRun;
      pc_plus4_q <= bus.pcPlus4In;
      instr_q    <= bus.instrIn;
      valid_q    <= 1'b1;
    end
  end

`ifdef IF_ID_HAZARD_STATS_EN
  logic [31:0] stall_count_q;
  logic [31:0] flush_count_q;

  always_ff @(posedge clk) begin
    if (startin) begin
      stall_count_q <= 32'd0;
      flush_count_q <= 32'd0;
    end else begin
      if (stall) begin
        stall_count_q <= stall_count_q + 32'd1;
      end
      if (bus.flush) begin
        flush_count_q <= flush_count_q + 32'd1;
      end
    end
  end

  assign bus.stallCount = stall_count_q;
  assign bus.flushCount = flush_count_q;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: reset, load-use stall, false-stall cases, flush priority,
// persistent hazard and (with IF_ID_HAZARD_STATS_EN) the statistics counters.
module tb_if_id_stage;

  logic clk;
  logic startin;
  int   n_vec;
  int   n_err;

  if_id_if bus ();

  if_id_stage dut (
    .clk     (clk),
    .startin (startin),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; inputs change and outputs are sampled 1ns after it.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    startin              = 1'b1;
    bus.instrIn          = 32'h8C43_0004;
    bus.pcPlus4In        = 32'h0000_0100;
    bus.flush            = 1'b0;
    bus.idExMemread      = 1'b0;
    bus.idExIns20_16     = 5'd0;
    for (int i = 0; i < 2; i++) begin
      cycle();
      n_vec++;
      if (bus.instr !== 32'd0 || bus.valid !== 1'b0 || bus.pcPlus4 !== 32'd0) begin
        n_err++;
        $display("FAIL reset_regs[%0d]: got instr=%h valid=%b pc=%h want 0/0/0", i,
                 bus.instr, bus.valid, bus.pcPlus4);
      end
      n_vec++;
      if (bus.pcWrite !== 1'b0 || bus.bubble !== 1'b0) begin
        n_err++;
        $display("FAIL reset_comb[%0d]: got pcWrite=%b bubble=%b want 0/0", i,
                 bus.pcWrite, bus.bubble);
      end
    end
`ifdef IF_ID_HAZARD_STATS_EN
    n_vec++;
    if (bus.stallCount !== 32'd0 || bus.flushCount !== 32'd0) begin
      n_err++;
      $display("FAIL reset_counters: got stall=%0d flush=%0d want 0/0", bus.stallCount,
               bus.flushCount);
    end
`endif
    startin = 1'b0;
    #1;
    n_vec++;
    if (bus.pcWrite !== 1'b1) begin
      n_err++;
      $display("FAIL release_pcwrite: got %b want 1", bus.pcWrite);
    end
    cycle();
    n_vec++;
    if (bus.instr !== 32'h8C43_0004 || bus.valid !== 1'b1 || bus.pcPlus4 !== 32'h100) begin
      n_err++;
      $display("FAIL release_load: got instr=%h valid=%b pc=%h want 8c430004/1/00000100",
               bus.instr, bus.valid, bus.pcPlus4);
    end
  endtask

  // Put 0x00622020 (rs=3, rt=2) into the register with no hazard active.
  task automatic load_add();
    bus.idExMemread  = 1'b0;
    bus.idExIns20_16 = 5'd0;
    bus.flush        = 1'b0;
    bus.instrIn      = 32'h0062_2020;
    bus.pcPlus4In    = 32'h0000_0010;
    cycle();
  endtask

  task automatic test_load_use();
    load_add();
    bus.idExMemread  = 1'b1;
    bus.idExIns20_16 = 5'd3;
    bus.instrIn      = 32'h1111_1111;
    bus.pcPlus4In    = 32'h0000_0020;
    #1;
    n_vec++;
    if (bus.pcWrite !== 1'b0 || bus.bubble !== 1'b1) begin
      n_err++;
      $display("FAIL lu_stall: got pcWrite=%b bubble=%b want 0/1", bus.pcWrite, bus.bubble);
    end
    cycle();
    n_vec++;
    if (bus.instr !== 32'h0062_2020 || bus.pcPlus4 !== 32'h10 || bus.valid !== 1'b1) begin
      n_err++;
      $display("FAIL lu_hold: got instr=%h pc=%h valid=%b want 00622020/00000010/1",
               bus.instr, bus.pcPlus4, bus.valid);
    end
    n_vec++;
    if (bus.pcWrite !== 1'b1 || bus.bubble !== 1'b0) begin
      n_err++;
      $display("FAIL lu_holdstate: got pcWrite=%b bubble=%b want 1/0", bus.pcWrite, bus.bubble);
    end
    cycle();
    n_vec++;
    if (bus.instr !== 32'h1111_1111 || bus.pcPlus4 !== 32'h20) begin
      n_err++;
      $display("FAIL lu_advance: got instr=%h pc=%h want 11111111/00000020", bus.instr,
               bus.pcPlus4);
    end
    bus.idExMemread = 1'b0;
  endtask

  task automatic test_no_false_stall();
    bus.idExMemread  = 1'b0;
    bus.idExIns20_16 = 5'd0;
    bus.instrIn      = 32'h0000_0020;
    cycle();
    bus.idExMemread  = 1'b1;
    bus.instrIn      = 32'h0000_0021;
    #1;
    n_vec++;
    if (bus.pcWrite !== 1'b1 || bus.bubble !== 1'b0) begin
      n_err++;
      $display("FAIL nfs_r0: got pcWrite=%b bubble=%b want 1/0", bus.pcWrite, bus.bubble);
    end
    cycle();
    n_vec++;
    if (bus.instr !== 32'h0000_0021) begin
      n_err++;
      $display("FAIL nfs_r0_adv: got instr=%h want 00000021", bus.instr);
    end
    load_add();
    bus.idExMemread  = 1'b0;
    bus.idExIns20_16 = 5'd2;
    bus.instrIn      = 32'h00A4_2820;
    #1;
    n_vec++;
    if (bus.pcWrite !== 1'b1 || bus.bubble !== 1'b0) begin
      n_err++;
      $display("FAIL nfs_nomem: got pcWrite=%b bubble=%b want 1/0", bus.pcWrite, bus.bubble);
    end
    cycle();
    n_vec++;
    if (bus.instr !== 32'h00A4_2820) begin
      n_err++;
      $display("FAIL nfs_nomem_adv: got instr=%h want 00a42820", bus.instr);
    end
  endtask

  task automatic test_flush_hazard();
    load_add();
    bus.idExMemread  = 1'b1;
    bus.idExIns20_16 = 5'd3;
    bus.flush        = 1'b1;
    bus.instrIn      = 32'h2222_2222;
    #1;
    n_vec++;
    if (bus.pcWrite !== 1'b1 || bus.bubble !== 1'b0) begin
      n_err++;
      $display("FAIL fl_comb: got pcWrite=%b bubble=%b want 1/0", bus.pcWrite, bus.bubble);
    end
    cycle();
    n_vec++;
    if (bus.instr !== 32'd0 || bus.valid !== 1'b0 || bus.pcPlus4 !== 32'd0) begin
      n_err++;
      $display("FAIL fl_squash: got instr=%h valid=%b pc=%h want 0/0/0", bus.instr,
               bus.valid, bus.pcPlus4);
    end
    bus.flush = 1'b0;
    #1;
    n_vec++;
    if (bus.bubble !== 1'b0 || bus.pcWrite !== 1'b1) begin
      n_err++;
      $display("FAIL fl_after: got pcWrite=%b bubble=%b want 1/0", bus.pcWrite, bus.bubble);
    end
    cycle();
    n_vec++;
    if (bus.instr !== 32'h2222_2222 || bus.valid !== 1'b1) begin
      n_err++;
      $display("FAIL fl_reload: got instr=%h valid=%b want 22222222/1", bus.instr, bus.valid);
    end
    bus.idExMemread = 1'b0;
  endtask

  task automatic test_back_to_back();
    int bubbles;
    startin = 1'b1;
    cycle();
    startin = 1'b0;
    load_add();
    bus.idExMemread  = 1'b1;
    bus.idExIns20_16 = 5'd3;
    bus.instrIn      = 32'h3333_3333;
    bubbles = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (bus.bubble === 1'b1) bubbles++;
      cycle();
    end
    n_vec++;
    if (bubbles != 1) begin
      n_err++;
      $display("FAIL b2b_bubbles: got %0d want 1", bubbles);
    end
    n_vec++;
    if (bus.instr !== 32'h3333_3333) begin
      n_err++;
      $display("FAIL b2b_instr: got %h want 33333333", bus.instr);
    end
`ifdef IF_ID_HAZARD_STATS_EN
    n_vec++;
    if (bus.stallCount !== 32'd1) begin
      n_err++;
      $display("FAIL b2b_stallcount: got %0d want 1", bus.stallCount);
    end
`endif
    bus.idExMemread = 1'b0;
  endtask

  task automatic test_reset_in_hold();
    load_add();
    bus.idExMemread  = 1'b1;
    bus.idExIns20_16 = 5'd3;
    cycle();
    startin   = 1'b1;
    bus.flush = 1'b1;
    #1;
    n_vec++;
    if (bus.pcWrite !== 1'b0 || bus.bubble !== 1'b0) begin
      n_err++;
      $display("FAIL rh_comb: got pcWrite=%b bubble=%b want 0/0", bus.pcWrite, bus.bubble);
    end
    cycle();
    startin   = 1'b0;
    bus.flush = 1'b0;
    cycle();
    n_vec++;
    if (bus.instr !== 32'h0062_2020 || bus.valid !== 1'b1) begin
      n_err++;
      $display("FAIL rh_load: got instr=%h valid=%b want 00622020/1", bus.instr, bus.valid);
    end
    // A fresh hazard must stall immediately, proving the state left HOLD on reset.
    n_vec++;
    if (bus.bubble !== 1'b1) begin
      n_err++;
      $display("FAIL rh_run: got bubble=%b want 1", bus.bubble);
    end
    bus.idExMemread = 1'b0;
    cycle();
  endtask

`ifdef IF_ID_HAZARD_STATS_EN
  task automatic test_counters();
    startin = 1'b1;
    cycle();
    startin   = 1'b0;
    bus.flush = 1'b1;
    for (int i = 0; i < 5; i++) cycle();
    load_add();
    bus.idExMemread  = 1'b1;
    bus.idExIns20_16 = 5'd3;
    for (int i = 0; i < 4; i++) cycle();
    bus.idExMemread = 1'b0;
    n_vec++;
    if (bus.flushCount !== 32'd5 || bus.stallCount !== 32'd2) begin
      n_err++;
      $display("FAIL cnt_values: got flush=%0d stall=%0d want 5/2", bus.flushCount,
               bus.stallCount);
    end
    startin = 1'b1;
    cycle();
    startin = 1'b0;
    n_vec++;
    if (bus.flushCount !== 32'd0 || bus.stallCount !== 32'd0) begin
      n_err++;
      $display("FAIL cnt_clear: got flush=%0d stall=%0d want 0/0", bus.flushCount,
               bus.stallCount);
    end
  endtask
`endif

  initial begin
    n_vec = 0;
    n_err = 0;
    startin          = 1'b1;
    bus.flush        = 1'b0;
    bus.idExMemread  = 1'b0;
    bus.idExIns20_16 = 5'd0;
    bus.instrIn      = 32'd0;
    bus.pcPlus4In    = 32'd0;
    #2;
    test_reset();
    test_load_use();
    test_no_false_stall();
    test_flush_hazard();
    test_back_to_back();
    test_reset_in_hold();
`ifdef IF_ID_HAZARD_STATS_EN
    test_counters();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; both ports are listed first below.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 startin  input  1  synchronous active-high reset.
REQ-004 pcPlus4In  input  32  PC+4 from the fetch stage.
REQ-005 instrIn  input  32  fetched instruction word.
REQ-006 flush  input  1  taken branch or jump resolved downstream; squash the fetched instruction.
REQ-007 idExMemread  input  1  memread output of the ID/EX register.
REQ-008 idExIns20_16  input  5  rt destination held in the ID/EX register.
REQ-009 pcPlus4  output  32  registered PC+4 presented to decode.
REQ-010 instr  output  32  registered instruction presented to decode.
REQ-011 valid  output  1  instr holds a live (non-squashed) instruction.
REQ-012 pcWrite  output  1  combinational; PC may advance this cycle.
REQ-013 bubble  output  1  combinational; decode must zero all control inputs of ID/EX this cycle.

Function
REQ-014 The FSM SHALL have two states: RUN and HOLD.
REQ-015 The load-use hazard SHALL be hz = RUN & valid & idExMemread & (idExIns20_16 != 0) & (idExIns20_16 == instr[25:21] | idExIns20_16 == instr[20:16]).
- Example: instr rs=3 matches idExIns20_16=3 with memread=1.
REQ-016 While hz=1 and flush=0, on the next edge:
- pcPlus4, instr and valid hold
- state goes to HOLD
- during the hz cycle, pcWrite=0 and bubble=1
REQ-017 In HOLD, hz SHALL be forced to 0, so the stall is exactly one cycle.
- At the next edge: load inputs, return to RUN, pcWrite=1, bubble=0.
REQ-018 When flush=1, on the next edge:
- instr<=0, pcPlus4<=0, valid<=0, state<=RUN
- flush SHALL take priority over hz and HOLD
- pcWrite=1, bubble=0 in the flush cycle
REQ-019 Otherwise, on each edge: instr<=instrIn, pcPlus4<=pcPlus4In, valid<=1.
REQ-020 Latency SHALL be one cycle from instrIn to instr; there SHALL be no internal buffering beyond one entry.
REQ-021 A hazard against register 0 SHALL never stall.
REQ-022 An invalid (squashed) instr SHALL never stall.

Reset
REQ-023 With startin=1 at an edge: instr=0, pcPlus4=0, valid=0, state=RUN, and any counters = 0.
REQ-024 While startin=1: pcWrite=0 and bubble=0 combinationally.
- startin SHALL override flush and hz, including reset asserted in HOLD.
REQ-025 On the first edge after startin falls, the block SHALL load instrIn normally.

Configuration
REQ-026 Macro IF_ID_HAZARD_STATS_EN SHALL select the statistics counters.
REQ-027 When defined, the block SHALL add two outputs:
- stallCount [31:0]: +1 each cycle bubble=1
- flushCount [31:0]: +1 each edge on which a flush is taken
- both counters wrap modulo 2^32
REQ-028 When undefined, these ports and counters SHALL be absent and the rest of the behaviour identical.

Verification
REQ-029 Reset: startin=1 for 2 cycles with instrIn=0x8C430004 -> instr=0, valid=0, pcWrite=0; first edge after release -> instr=0x8C430004, valid=1.
REQ-030 Load-use: instr=0x00622020 (rs=3, rt=2), idExMemread=1, idExIns20_16=3 -> one cycle with pcWrite=0, bubble=1 and instr held; next edge loads the new instrIn, pcWrite=1.
REQ-031 No false stall in either case below -> no stall, instr advances every cycle:
- idExIns20_16=0 with instr rs=0
- idExMemread=0 with a matching rt
REQ-032 Flush during hazard: hz=1 and flush=1 in the same cycle -> next edge instr=0, valid=0, state RUN; no bubble in the following cycle.
REQ-033 Back-to-back: hazard persists for 3 cycles (memread held 1 by the bench) -> exactly one bubble cycle, then RUN.
- With IF_ID_HAZARD_STATS_EN defined: stallCount=1.
REQ-034 Counters (macro defined): 5 flushes and 2 stalls -> flushCount=5, stallCount=2; startin then clears both to 0.
